// File: rtl/bcd_operand_loader_pkg.sv
// Shared encodings for the BCD operand-entry stage: FSM states, slot width, largest legal digit.
package bcd_operand_loader_pkg;

   localparam int SLOT_W = 3;
   localparam logic [3:0] BCD_MAX = 4'd9;

   // The state value doubles as the slot index that is shown to the user.
   typedef enum logic [SLOT_W-1:0] {
      S_A1   = 3'd0,
      S_A0   = 3'd1,
      S_B1   = 3'd2,
      S_B0   = 3'd3,
      S_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/bcd_operand_loader_key_debounce.sv
// Raw active-low key -> synchronised, debounced level -> one-cycle press strobe on its 1->0 edge.
// Latency: a stable press gives a strobe 2 + DEBOUNCE_CYCLES cycles later; a release gives no strobe.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic CLOCK_50,
   input  logic resetn,
   input  logic key_n,
   output logic press_pulse
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             db_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         db_q        <= 1'b1;
         cnt_q       <= '0;
         press_pulse <= 1'b0;
      end else begin
         sync1_q     <= key_n;
         sync2_q     <= sync1_q;
         press_pulse <= 1'b0;
         if (sync2_q == db_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            // The level flips here; a flip away from 1 is a press.
            db_q        <= ~db_q;
            cnt_q       <= '0;
            press_pulse <= db_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_operand_loader.sv
// Collects four BCD digits A1,A0,B1,B0 from SW using debounced enter/clear keys; flags non-BCD entries.
// Latency: digit registers update one cycle after a press strobe; clear has priority over enter.
module bcd_operand_loader
   import bcd_operand_loader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   input  logic [3:0]        SW,
   input  logic              key_enter,
   input  logic              key_clear,
   output logic [3:0]        A1,
   output logic [3:0]        A0,
   output logic [3:0]        B1,
   output logic [3:0]        B0,
   output logic [SLOT_W-1:0] slot,
   output logic              ops_valid,
   output logic              bcd_err
);

   logic       enter_p;
   logic       clear_p;
   logic [3:0] sw_s1_q;
   logic [3:0] sw_s2_q;

   state_t     state_q, state_d;
   logic [3:0] a1_d, a0_d, b1_d, b0_d;
   logic       err_d;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter_db (
      .CLOCK_50    (CLOCK_50),
      .resetn      (resetn),
      .key_n       (key_enter),
      .press_pulse (enter_p)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear_db (
      .CLOCK_50    (CLOCK_50),
      .resetn      (resetn),
      .key_n       (key_clear),
      .press_pulse (clear_p)
   );

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         sw_s1_q   <= '0;
         sw_s2_q   <= '0;
         state_q   <= S_A1;
         A1        <= '0;
         A0        <= '0;
         B1        <= '0;
         B0        <= '0;
         ops_valid <= 1'b0;
         bcd_err   <= 1'b0;
      end else begin
         sw_s1_q   <= SW;
         sw_s2_q   <= sw_s1_q;
         state_q   <= state_d;
         A1        <= a1_d;
         A0        <= a0_d;
         B1        <= b1_d;
         B0        <= b0_d;
         ops_valid <= (state_d == S_DONE);
         bcd_err   <= err_d;
      end
   end

   always_comb begin
      state_d = (state_q > S_DONE) ? S_A1 : state_q;
      a1_d    = A1;
      a0_d    = A0;
      b1_d    = B1;
      b0_d    = B0;
      err_d   = bcd_err;

      if (clear_p) begin
         state_d = S_A1;
         a1_d    = '0;
         a0_d    = '0;
         b1_d    = '0;
         b0_d    = '0;
         err_d   = 1'b0;
      end else if (enter_p) begin
         case (state_q)
            S_A1, S_A0, S_B1, S_B0: begin
               if (sw_s2_q > BCD_MAX) begin
                  err_d = 1'b1;
               end else begin
                  err_d   = 1'b0;
                  state_d = state_t'(state_q + 3'd1);
                  case (state_q)
                     S_A1:    a1_d = sw_s2_q;
                     S_A0:    a0_d = sw_s2_q;
                     S_B1:    b1_d = sw_s2_q;
                     default: b0_d = sw_s2_q;
                  endcase
               end
            end
            // Restart keeps the old digits; they are overwritten one by one.
            S_DONE:  state_d = S_A1;
            default: state_d = S_A1;
         endcase
      end
   end

   assign slot = state_q;

endmodule
